// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the adder round-robin scheduler.
// tag_t is sized for the largest supported requester count; users cast
// results down to their own tag width.
package adder_sched_pkg;

   localparam int MAX_REQ   = 32;
   localparam int MAX_TAG_W = 5;

   typedef logic [MAX_TAG_W-1:0] tag_t;

   // Width of a requester tag; a single bit still needed for two requesters.
   function automatic int tag_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // First valid index at or after ptr, wrapping modulo n. Returns ptr if none.
   function automatic tag_t rr_pick(input logic [MAX_REQ-1:0] vld,
                                    input tag_t ptr,
                                    input int unsigned n);
      tag_t        g;
      logic        found;
      int unsigned idx;
      g     = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         idx = (32'(ptr) + i) % n;
         if (i < n && !found && vld[idx[MAX_TAG_W-1:0]]) begin
            g     = idx[MAX_TAG_W-1:0];
            found = 1'b1;
         end
      end
      return g;
   endfunction

   // Successor of g modulo n.
   function automatic tag_t rr_next(input tag_t g, input int unsigned n);
      return (32'(g) + 32'd1 >= n) ? '0 : g + tag_t'(1);
   endfunction

endpackage

// File: rtl/adder_sched_tag_fifo.sv
// In-order tag FIFO for the adder scheduler. Holds the requester tag of each
// issued-but-unreturned operation. Push while full is legal only together
// with a pop in the same cycle (the slot being freed is the one written).
module adder_sched_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign dout  = mem_q[rd_q];
   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);

   // Next-state: write at tail, advance pointers with wrap, track occupancy.
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[wr_q] = din;
         wr_d        = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      end
      if (pop) begin
         rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one flow-controlled adder among n_req
// requesters. Operands are registered toward the adder; returned sums are
// steered to their requester using an in-order tag FIFO.
// Optional: define ADDER_RR_SCHEDULER_PERF_EN to add perf_issued/perf_stall.
module adder_rr_scheduler
   import adder_sched_pkg::*;
#(
   parameter int width     = 8,
   parameter int n_req     = 4,
   parameter int max_outst = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [n_req-1:0]         req_vld,
   output logic [n_req-1:0]         req_rdy,
   input  logic [n_req*width-1:0]   req_a,
   input  logic [n_req*width-1:0]   req_b,
   output logic                     add_a_vld,
   input  logic                     add_a_rdy,
   output logic [width-1:0]         add_a_data,
   output logic                     add_b_vld,
   input  logic                     add_b_rdy,
   output logic [width-1:0]         add_b_data,
   input  logic                     add_s_vld,
   output logic                     add_s_rdy,
   input  logic [width:0]           add_s_data,
   output logic [n_req-1:0]         rsp_vld,
   input  logic [n_req-1:0]         rsp_rdy,
   output logic [width:0]           rsp_data
`ifdef ADDER_RR_SCHEDULER_PERF_EN
   ,
   output logic [31:0]              perf_issued,
   output logic [31:0]              perf_stall
`endif
);

   localparam int TW = tag_w(n_req);

   logic [width-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
   logic               a_pend_q, a_pend_d, b_pend_q, b_pend_d;
   logic [TW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [MAX_REQ-1:0] vld_pad;
   logic [TW-1:0]      grant, head;
   logic               stage_free, load, pop, full, empty;

   assign add_a_vld  = a_pend_q;
   assign add_b_vld  = b_pend_q;
   assign add_a_data = op_a_q;
   assign add_b_data = op_b_q;
   assign rsp_data   = add_s_data;

   // Arbitration, issue and return steering.
   // load is qualified by rst_n so no requester is acknowledged while reset is held.
   always_comb begin
      vld_pad              = '0;
      vld_pad[n_req-1:0]   = req_vld;
      grant      = TW'(rr_pick(vld_pad, tag_t'(rr_ptr_q), n_req));
      stage_free = (~a_pend_q | add_a_rdy) & (~b_pend_q | add_b_rdy);
      add_s_rdy  = ~empty & rsp_rdy[head];
      pop        = add_s_vld & add_s_rdy;
      load       = rst_n & stage_free & (|req_vld) & (~full | pop);
      req_rdy    = '0;
      if (load) req_rdy[grant] = 1'b1;
      rsp_vld    = '0;
      if (add_s_vld && !empty) rsp_vld[head] = 1'b1;
   end

   // Operand stage and pointer next-state; each channel drains independently.
   always_comb begin
      a_pend_d = a_pend_q & ~add_a_rdy;
      b_pend_d = b_pend_q & ~add_b_rdy;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      rr_ptr_d = rr_ptr_q;
      if (load) begin
         a_pend_d = 1'b1;
         b_pend_d = 1'b1;
         op_a_d   = req_a[grant*width +: width];
         op_b_d   = req_b[grant*width +: width];
         rr_ptr_d = TW'(rr_next(tag_t'(grant), n_req));
      end
   end

   // Operand stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q   <= '0;
         op_b_q   <= '0;
         a_pend_q <= 1'b0;
         b_pend_q <= 1'b0;
         rr_ptr_q <= '0;
      end else begin
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         a_pend_q <= a_pend_d;
         b_pend_q <= b_pend_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   adder_sched_tag_fifo #(
      .DEPTH (max_outst),
      .W     (TW)
   ) u_tag_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (load),
      .din   (grant),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

`ifdef ADDER_RR_SCHEDULER_PERF_EN
   logic [31:0] perf_issued_q, perf_issued_d, perf_stall_q, perf_stall_d;

   assign perf_issued = perf_issued_q;
   assign perf_stall  = perf_stall_q;

   // Free-running counters of issued operations and blocked request cycles.
   always_comb begin
      perf_issued_d = perf_issued_q + {31'd0, load};
      perf_stall_d  = perf_stall_q + {31'd0, (|req_vld) & ~load};
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_issued_q <= perf_issued_d;
         perf_stall_q  <= perf_stall_d;
      end
   end
`endif

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler with a behavioural flow-controlled adder partner.
// Expected sums are computed from requester operands at handshake time and
// queued per requester; each returned response is popped and compared.
module tb_adder_rr_scheduler;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int MO = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [N-1:0]       req_vld = '0;
   logic [N-1:0]       req_rdy;
   logic [N*W-1:0]     req_a = '0;
   logic [N*W-1:0]     req_b = '0;
   logic               add_a_vld, add_b_vld, add_s_rdy;
   logic               add_a_rdy = 1'b0, add_b_rdy = 1'b0, add_s_vld = 1'b0;
   logic [W-1:0]       add_a_data, add_b_data;
   logic [W:0]         add_s_data = '0;
   logic [N-1:0]       rsp_vld;
   logic [N-1:0]       rsp_rdy = '0;
   logic [W:0]         rsp_data;
`ifdef ADDER_RR_SCHEDULER_PERF_EN
   logic [31:0]        perf_issued, perf_stall;
`endif

   always #5 clk = ~clk;

   adder_rr_scheduler #(.width(W), .n_req(N), .max_outst(MO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_vld    (req_vld),
      .req_rdy    (req_rdy),
      .req_a      (req_a),
      .req_b      (req_b),
      .add_a_vld  (add_a_vld),
      .add_a_rdy  (add_a_rdy),
      .add_a_data (add_a_data),
      .add_b_vld  (add_b_vld),
      .add_b_rdy  (add_b_rdy),
      .add_b_data (add_b_data),
      .add_s_vld  (add_s_vld),
      .add_s_rdy  (add_s_rdy),
      .add_s_data (add_s_data),
      .rsp_vld    (rsp_vld),
      .rsp_rdy    (rsp_rdy),
      .rsp_data   (rsp_data)
`ifdef ADDER_RR_SCHEDULER_PERF_EN
      ,
      .perf_issued(perf_issued),
      .perf_stall (perf_stall)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // stimulus knobs (percent probabilities)
   int unsigned req_pct = 100, ardy_pct = 100, rsp_pct = 100, s_pct = 100;
   logic [N-1:0] rsp_mask = '1;

   // requester op queues, scoreboard, adder partner state
   logic [W-1:0] opa_q [N][$];
   logic [W-1:0] opb_q [N][$];
   logic [W:0]   exp_q [N][$];
   logic [W-1:0] qa [$];
   logic [W-1:0] qb [$];
   logic [W:0]   sq [$];
   int           grant_q [$];
   int           load_cnt [N];
   int           rsp_cnt [N];
   logic [W:0]   last_rsp [N];
   logic [N-1:0] req_fired = '0;
   logic         s_fired = 1'b0;

   initial for (int i = 0; i < N; i++) begin
      load_cnt[i] = 0; rsp_cnt[i] = 0; last_rsp[i] = '0;
   end

   task automatic push_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
      opa_q[r].push_back(a);
      opb_q[r].push_back(b);
   endtask

   // Monitor: evaluate the handshakes that complete at the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            opa_q[i].delete(); opb_q[i].delete(); exp_q[i].delete();
         end
         qa.delete(); qb.delete(); sq.delete();
         req_fired = '0;
         s_fired   = 1'b0;
      end else begin
         chk("req_rdy_onehot", 32'(req_rdy & (req_rdy - 1'b1)), 0);
         chk("rsp_vld_onehot", 32'(rsp_vld & (rsp_vld - 1'b1)), 0);
         for (int i = 0; i < N; i++) begin
            req_fired[i] = req_vld[i] & req_rdy[i];
            if (req_fired[i]) begin
               exp_q[i].push_back({1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]});
               void'(opa_q[i].pop_front());
               void'(opb_q[i].pop_front());
               grant_q.push_back(i);
               load_cnt[i]++;
            end
            if (rsp_vld[i] && rsp_rdy[i]) begin
               rsp_cnt[i]++;
               last_rsp[i] = rsp_data;
               if (exp_q[i].size() == 0) chk($sformatf("rsp%0d_unexpected", i), 1, 0);
               else chk($sformatf("rsp%0d_data", i), 32'(rsp_data), 32'(exp_q[i].pop_front()));
            end
         end
         if (add_a_vld && add_a_rdy) qa.push_back(add_a_data);
         if (add_b_vld && add_b_rdy) qb.push_back(add_b_data);
         s_fired = add_s_vld & add_s_rdy;
         if (s_fired) void'(sq.pop_front());
         while (qa.size() > 0 && qb.size() > 0) begin
            logic [W-1:0] ta, tb;
            ta = qa.pop_front();
            tb = qb.pop_front();
            sq.push_back({1'b0, ta} + {1'b0, tb});
         end
      end
   end

   // Driver: requesters (sticky valid) and adder partner, just after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         req_vld   = '0;
         rsp_rdy   = '0;
         add_a_rdy = 1'b0;
         add_b_rdy = 1'b0;
         add_s_vld = 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!(req_vld[i] && !req_fired[i])) begin
               req_vld[i] = (opa_q[i].size() > 0) && ($urandom_range(0, 99) < req_pct);
               if (opa_q[i].size() > 0) begin
                  req_a[i*W +: W] = opa_q[i][0];
                  req_b[i*W +: W] = opb_q[i][0];
               end
            end
            rsp_rdy[i] = rsp_mask[i] && ($urandom_range(0, 99) < rsp_pct);
         end
         add_a_rdy = ($urandom_range(0, 99) < ardy_pct);
         add_b_rdy = ($urandom_range(0, 99) < ardy_pct);
         if (!(add_s_vld && !s_fired)) begin
            add_s_vld  = (sq.size() > 0) && ($urandom_range(0, 99) < s_pct);
            add_s_data = (sq.size() > 0) ? sq[0] : '0;
         end
      end
   end

   function automatic bit all_idle();
      bit idle = 1'b1;
      for (int i = 0; i < N; i++)
         if (opa_q[i].size() != 0 || exp_q[i].size() != 0) idle = 1'b0;
      return idle;
   endfunction

   task automatic wait_idle(input string tag, input int max_cyc);
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         #1;
         if (all_idle()) return;
      end
      chk({tag, "_timeout"}, 1, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_a_vld"}, 32'(add_a_vld), 0);
      chk({tag, "_b_vld"}, 32'(add_b_vld), 0);
      chk({tag, "_req_rdy"}, 32'(req_rdy), 0);
      chk({tag, "_rsp_vld"}, 32'(rsp_vld), 0);
      chk({tag, "_s_rdy"}, 32'(add_s_rdy), 0);
   endtask

   int snap_rsp [N];
   int snap_load;
   int tot;

   initial begin
      // reset state
      #3;
      chk_reset_outputs("reset");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // all four valid from pointer 0: grants rotate 0,1,2,3,0,1,2,3
      @(negedge clk); #2;
      grant_q.delete();
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < N; r++) push_op(r, 8'(r * 16 + k), 8'(k + 1));
      wait_idle("rr", 200);
      chk("rr_count", grant_q.size(), 8);
      for (int k = 0; k < grant_q.size() && k < 8; k++)
         chk($sformatf("rr_grant%0d", k), grant_q[k], k % N);

      // single request 3+5
      for (int i = 0; i < N; i++) snap_rsp[i] = rsp_cnt[i];
      push_op(0, 8'd3, 8'd5);
      wait_idle("single", 100);
      chk("single_rsp0_cnt", rsp_cnt[0] - snap_rsp[0], 1);
      chk("single_other_cnt", (rsp_cnt[1] - snap_rsp[1]) + (rsp_cnt[2] - snap_rsp[2]) +
          (rsp_cnt[3] - snap_rsp[3]), 0);
      chk("single_sum", 32'(last_rsp[0]), 32'd8);

      // carry out of the top bit
      push_op(0, 8'd255, 8'd255);
      wait_idle("ovf", 100);
      chk("ovf_sum", 32'(last_rsp[0]), 32'h1FE);

      // requester 1 blocked on response: issue stops at max_outst
      rsp_mask  = 4'b1101;
      snap_load = load_cnt[1];
      snap_rsp[1] = rsp_cnt[1];
      for (int k = 0; k < 6; k++) push_op(1, 8'(k * 10 + 7), 8'(k));
      repeat (20) @(negedge clk);
      #1;
      chk("outst_loads", load_cnt[1] - snap_load, MO);
      chk("outst_req_rdy", 32'(req_rdy), 0);
      chk("outst_no_rsp", rsp_cnt[1] - snap_rsp[1], 0);
      @(negedge clk); #2;
      rsp_mask = '1;
      wait_idle("outst", 200);
      chk("outst_loads_all", load_cnt[1] - snap_load, 6);
      chk("outst_rsp_all", rsp_cnt[1] - snap_rsp[1], 6);

      // random traffic with backpressure everywhere
      req_pct = 70; ardy_pct = 60; rsp_pct = 60; s_pct = 70;
      for (int i = 0; i < N; i++) snap_rsp[i] = rsp_cnt[i];
      for (int k = 0; k < 1000; k++)
         push_op(int'($urandom_range(0, N - 1)), 8'($urandom), 8'($urandom));
      wait_idle("rand", 30000);
      tot = 0;
      for (int i = 0; i < N; i++) tot += rsp_cnt[i] - snap_rsp[i];
      chk("rand_total", tot, 1000);

      // reset with three operations outstanding
      req_pct = 100; ardy_pct = 100; rsp_pct = 100; s_pct = 100;
      rsp_mask  = 4'b0000;
      snap_load = load_cnt[2];
      for (int k = 0; k < 3; k++) push_op(2, 8'(k + 1), 8'(k + 2));
      for (int c = 0; c < 50 && (load_cnt[2] - snap_load) < 3; c++) @(negedge clk);
      chk("rst_outst_loads", load_cnt[2] - snap_load, 3);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      #2;
      rst_n    = 1'b1;
      rsp_mask = '1;
      grant_q.delete();
      push_op(3, 8'd10, 8'd20);
      push_op(1, 8'd30, 8'd40);
      wait_idle("postrst", 100);
      chk("postrst_count", grant_q.size(), 2);
      if (grant_q.size() > 0) chk("postrst_first", grant_q[0], 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
